// File: rtl/segment_chaser_pkg.sv
// Shared constants and types for the segment chaser: the default figure-8 path,
// the segment-index width helper, fade-mode encodings and the bounce direction type.
package segment_chaser_pkg;

    function automatic int seg_idx_w(input int num_seg);
        return (num_seg > 1) ? $clog2(num_seg) : 1;
    endfunction

    localparam int FIG8_STEPS = 8;
    localparam int FIG8_IDX_W = 3;

    // Path 0,1,6,4,3,2,6,5 with step 0 in the least significant bits.
    localparam logic [FIG8_STEPS*FIG8_IDX_W-1:0] SEG_FIG8_SEQ =
        {3'd5, 3'd6, 3'd2, 3'd3, 3'd4, 3'd6, 3'd1, 3'd0};

    localparam logic FADE_SHIFT  = 1'b0;
    localparam logic FADE_LINEAR = 1'b1;

    // Up encodes as zero so that a cleared register means "up".
    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } bounce_dir_e;

endpackage

// File: rtl/segment_chaser_pwm_channel.sv
// One display segment: brightness register with head/clear/decay priority,
// followed by a registered PWM compare against the shared counter.
module seg_pwm_channel
    import segment_chaser_pkg::*;
#(
    parameter int FADE_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  is_head_i,
    input  logic                  tail_en_i,
    input  logic                  fade_tick_i,
    input  logic                  fade_mode_i,
    input  logic [FADE_WIDTH-1:0] pwm_cnt_i,
    output logic                  led_o
);

    logic [FADE_WIDTH-1:0] bright_q, bright_d;
    logic                  led_q;

    always_comb begin
        bright_d = bright_q;
        if (is_head_i) begin
            bright_d = '1;
        end else if (!tail_en_i) begin
            bright_d = '0;
        end else if (fade_tick_i) begin
            case (fade_mode_i)
                FADE_LINEAR: bright_d = (bright_q == '0) ? '0 : bright_q - 1'b1;
                FADE_SHIFT:  bright_d = bright_q >> 1;
            endcase
        end
    end

    // Strict compare: full scale is dark for one count, zero is never lit.
    always_ff @(posedge clk) begin
        if (reset) begin
            bright_q <= '0;
            led_q    <= 1'b0;
        end else begin
            bright_q <= bright_d;
            led_q    <= (bright_q > pwm_cnt_i);
        end
    end

    assign led_o = led_q;

endmodule

// File: rtl/segment_chaser_pwm.sv
// Seven-segment chaser: a lit head walks a programmable segment path at a
// selectable rate (wrap or ping-pong), leaving a PWM-faded tail behind it.
module segment_chaser_pwm
    import segment_chaser_pkg::*;
#(
    parameter int NUM_SEG        = 7,
    parameter int STEP_COUNT     = 8,
    localparam int SEG_IDX_W     = seg_idx_w(NUM_SEG),
    parameter logic [STEP_COUNT*SEG_IDX_W-1:0] SEQ = SEG_FIG8_SEQ,
    parameter int FADE_WIDTH     = 4,
    parameter int PRESCALE_WIDTH = 23,
    parameter int FADE_DIV_WIDTH = 22,
    localparam int POS_W         = $clog2(STEP_COUNT)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [2:0]         speed,
    input  logic               direction,
    input  logic               bounce,
    input  logic               tail_en,
    input  logic               fade_linear,
    input  logic               pause,
    input  logic               invert,
    output logic [NUM_SEG-1:0] led_out,
    output logic [POS_W-1:0]   pos,
    output logic               step_pulse
);

    localparam logic [POS_W-1:0] LAST_POS = POS_W'(STEP_COUNT - 1);

    for (genvar k = 0; k < STEP_COUNT; k++) begin : g_seq_check
        if (int'(SEQ[k*SEG_IDX_W +: SEG_IDX_W]) >= NUM_SEG) begin : g_bad_entry
            $error("segment_chaser_pwm: SEQ entry %0d names a segment that does not exist", k);
        end
    end

    logic [2:0] speed_q;
    logic       direction_q, bounce_q, bounce_d1_q, tail_en_q, fade_linear_q, pause_q, invert_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            speed_q       <= '0;
            direction_q   <= 1'b0;
            bounce_q      <= 1'b0;
            bounce_d1_q   <= 1'b0;
            tail_en_q     <= 1'b0;
            fade_linear_q <= 1'b0;
            pause_q       <= 1'b0;
            invert_q      <= 1'b0;
        end else begin
            speed_q       <= speed;
            direction_q   <= direction;
            bounce_q      <= bounce;
            bounce_d1_q   <= bounce_q;
            tail_en_q     <= tail_en;
            fade_linear_q <= fade_linear;
            pause_q       <= pause;
            invert_q      <= invert;
        end
    end

    // A >= compare lets a mid-count speed decrease wrap at once instead of overrunning.
    logic [PRESCALE_WIDTH-1:0] presc_q, presc_d, presc_limit;
    logic                      step_tick;

    assign presc_limit = {speed_q, {(PRESCALE_WIDTH-3){1'b1}}};

    always_comb begin
        presc_d   = presc_q;
        step_tick = 1'b0;
        if (!pause_q) begin
            if (presc_q >= presc_limit) begin
                presc_d   = '0;
                step_tick = 1'b1;
            end else begin
                presc_d = presc_q + 1'b1;
            end
        end
    end

    logic [POS_W-1:0] pos_q, pos_d;
    bounce_dir_e      bounce_dir_q, bounce_dir_d, dir_eff;
    logic             step_pulse_q;

    always_comb begin
        dir_eff = bounce_dir_q;
        if (bounce_q && !bounce_d1_q) begin
            dir_eff = direction_q ? DIR_UP : DIR_DOWN;
        end
        bounce_dir_d = dir_eff;
        pos_d        = pos_q;
        if (step_tick) begin
            if (bounce_q) begin
                if (dir_eff == DIR_UP) begin
                    if (pos_q == LAST_POS) begin
                        pos_d        = pos_q - 1'b1;
                        bounce_dir_d = DIR_DOWN;
                    end else begin
                        pos_d = pos_q + 1'b1;
                    end
                end else begin
                    if (pos_q == '0) begin
                        pos_d        = POS_W'(1);
                        bounce_dir_d = DIR_UP;
                    end else begin
                        pos_d = pos_q - 1'b1;
                    end
                end
            end else if (direction_q) begin
                pos_d = (pos_q == LAST_POS) ? '0 : pos_q + 1'b1;
            end else begin
                pos_d = (pos_q == '0) ? LAST_POS : pos_q - 1'b1;
            end
        end
    end

    logic [FADE_DIV_WIDTH-1:0] fade_div_q;
    logic [FADE_WIDTH-1:0]     pwm_cnt_q;
    logic                      fade_tick;

    assign fade_tick = &fade_div_q;

    // step_pulse qualifies pos: it is high exactly in the first cycle pos shows a new value.
    always_ff @(posedge clk) begin
        if (reset) begin
            presc_q      <= '0;
            pos_q        <= '0;
            bounce_dir_q <= DIR_UP;
            step_pulse_q <= 1'b0;
            fade_div_q   <= '0;
            pwm_cnt_q    <= '0;
        end else begin
            presc_q      <= presc_d;
            pos_q        <= pos_d;
            bounce_dir_q <= bounce_dir_d;
            step_pulse_q <= step_tick;
            fade_div_q   <= fade_div_q + 1'b1;
            pwm_cnt_q    <= pwm_cnt_q + 1'b1;
        end
    end

    logic [SEG_IDX_W-1:0] head_idx;
    logic [NUM_SEG-1:0]   led_reg;

    assign head_idx = SEQ[int'(pos_q)*SEG_IDX_W +: SEG_IDX_W];

    for (genvar s = 0; s < NUM_SEG; s++) begin : g_chan
        seg_pwm_channel #(
            .FADE_WIDTH (FADE_WIDTH)
        ) u_chan (
            .clk         (clk),
            .reset       (reset),
            .is_head_i   (head_idx == SEG_IDX_W'(s)),
            .tail_en_i   (tail_en_q),
            .fade_tick_i (fade_tick),
            .fade_mode_i (fade_linear_q),
            .pwm_cnt_i   (pwm_cnt_q),
            .led_o       (led_reg[s])
        );
    end

    assign led_out    = led_reg ^ {NUM_SEG{invert_q}};
    assign pos        = pos_q;
    assign step_pulse = step_pulse_q;

endmodule

// File: tb/tb_segment_chaser_pwm.sv
// Bench for segment_chaser_pwm: directed phases plus random control changes,
// checked against a behavioural model through an output queue and a step queue.
module tb_segment_chaser_pwm;

    localparam int NSEG  = 7;
    localparam int STEPS = 8;

    logic       clk = 1'b0;
    logic       reset, direction, bounce, tail_en, fade_linear, pause, invert;
    logic [2:0] speed;
    logic [6:0] led_out;
    logic [2:0] pos;
    logic       step_pulse;

    segment_chaser_pwm #(
        .PRESCALE_WIDTH (6),
        .FADE_DIV_WIDTH (5),
        .FADE_WIDTH     (4)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .speed       (speed),
        .direction   (direction),
        .bounce      (bounce),
        .tail_en     (tail_en),
        .fade_linear (fade_linear),
        .pause       (pause),
        .invert      (invert),
        .led_out     (led_out),
        .pos         (pos),
        .step_pulse  (step_pulse)
    );

    always #5 clk = ~clk;

    int         seq_tbl [STEPS] = '{0, 1, 6, 4, 3, 2, 6, 5};
    logic [9:0] exp_q[$];
    int         step_pos_q[$];
    int         step_cyc_q[$];
    int         chk_cnt  = 0;
    int         pass_cnt = 0;
    int         g_cyc    = 0;

    task automatic check(input string name, input int act, input int exp);
        chk_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, g_cyc);
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Behavioural model: inputs take effect one edge after they are sampled,
    // the head lights its segment next cycle, the led bit follows a cycle later.
    initial begin : model
        int         m_speed, presc, mpos, k, pwm, head;
        bit         m_dir, m_bounce, m_bprev, m_tail, m_lin, m_pause, inv, up, pulse, tick, fade;
        int         bright [NSEG];
        logic [6:0] led_reg, new_led;
        m_speed = 0; presc = 0; mpos = 0; k = 0;
        m_dir = 0; m_bounce = 0; m_bprev = 0; m_tail = 0; m_lin = 0; m_pause = 0;
        inv = 0; up = 1; pulse = 0; led_reg = '0;
        foreach (bright[i]) bright[i] = 0;
        forever begin
            @(posedge clk);
            g_cyc++;
            if (reset) begin
                m_speed = 0; presc = 0; mpos = 0; k = 0;
                m_dir = 0; m_bounce = 0; m_bprev = 0; m_tail = 0; m_lin = 0; m_pause = 0;
                inv = 0; up = 1; pulse = 0; led_reg = '0;
                foreach (bright[i]) bright[i] = 0;
            end else begin
                pwm  = k % 16;
                fade = (k % 32) == 31;
                tick = !m_pause && (presc >= m_speed * 8 + 7);
                for (int i = 0; i < NSEG; i++) new_led[i] = bright[i] > pwm;
                head = seq_tbl[mpos];
                for (int i = 0; i < NSEG; i++) begin
                    if (i == head)        bright[i] = 15;
                    else if (!m_tail)     bright[i] = 0;
                    else if (fade && m_lin) bright[i] = (bright[i] > 0) ? bright[i] - 1 : 0;
                    else if (fade)        bright[i] = bright[i] / 2;
                end
                if (m_bounce && !m_bprev) up = m_dir;
                if (tick) begin
                    if (m_bounce) begin
                        if (up && mpos == STEPS - 1) begin mpos = STEPS - 2; up = 0; end
                        else if (!up && mpos == 0)   begin mpos = 1; up = 1; end
                        else mpos = up ? mpos + 1 : mpos - 1;
                    end else begin
                        mpos = m_dir ? (mpos + 1) % STEPS : (mpos + STEPS - 1) % STEPS;
                    end
                end
                if (!m_pause) presc = tick ? 0 : presc + 1;
                pulse   = tick;
                led_reg = new_led;
                m_bprev = m_bounce;
                m_speed = int'(speed); m_dir = direction; m_bounce = bounce;
                m_tail = tail_en; m_lin = fade_linear; m_pause = pause; inv = invert;
                k++;
            end
            exp_q.push_back({led_reg ^ {7{inv}}, 3'(mpos)});
            if (pulse) begin
                step_pos_q.push_back(mpos);
                step_cyc_q.push_back(g_cyc);
            end
        end
    end

    initial begin : monitor
        logic [9:0] e;
        int         p, c;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("led_out", int'(led_out), int'(e[9:3]));
                check("pos", int'(pos), int'(e[2:0]));
            end
            if (step_pulse === 1'b1) begin
                if (step_pos_q.size() == 0) begin
                    check("step_pulse_unexpected", int'(step_pulse), 0);
                end else begin
                    p = step_pos_q.pop_front();
                    c = step_cyc_q.pop_front();
                    check("step_pos", int'(pos), p);
                    check("step_cycle", g_cyc, c);
                end
            end else if (step_pos_q.size() > 0 && step_cyc_q[0] <= g_cyc) begin
                check("step_pulse_missed", int'(step_pulse), 1);
                void'(step_pos_q.pop_front());
                void'(step_cyc_q.pop_front());
            end
        end
    end

    initial begin : stimulus
        reset = 1; invert = 1; speed = 0; direction = 0; bounce = 0;
        tail_en = 0; fade_linear = 0; pause = 0;
        cycles(3);
        reset = 0; direction = 1;
        cycles(100);
        invert = 0;
        cycles(100);
        direction = 0;
        cycles(60);
        speed = 3;
        cycles(160);
        speed = 0; direction = 1;
        cycles(20);
        bounce = 1;
        cycles(300);
        bounce = 0; tail_en = 1; fade_linear = 0;
        cycles(300);
        fade_linear = 1;
        cycles(700);
        cycles(3);
        pause = 1;
        cycles(100);
        pause = 0;
        cycles(100);
        repeat (30) begin
            case ($urandom_range(0, 3))
                0:       bounce = ~bounce;
                1:       direction = ~direction;
                default: ;
            endcase
            speed       = 3'($urandom_range(0, 7));
            tail_en     = 1'($urandom_range(0, 1));
            fade_linear = 1'($urandom_range(0, 1));
            invert      = 1'($urandom_range(0, 1));
            pause       = ($urandom_range(0, 4) == 0);
            cycles($urandom_range(20, 150));
        end
        pause = 0; bounce = 0; tail_en = 1; speed = 1;
        reset = 1;
        cycles(2);
        reset = 0;
        cycles(120);
        @(negedge clk);
        #2;
        check("step_queue_drained", step_pos_q.size(), 0);
        check("output_queue_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/segment_chaser_pwm.md
Name: segment_chaser_pwm

Overview:
- Parametrised successor to the seven-segment figure-8 chaser.
- Steps a lit "head" around a programmable segment sequence at a selectable speed, with a PWM-faded tail behind it.
- Adds bounce mode, linear/exponential decay, pause, and configurable width/depth.
- Sits between the TinyTapeout io_in/io_out wrapper and the display pins, one instance per display.

Parameters:
- NUM_SEG, 7, number of segment outputs.
- STEP_COUNT, 8, number of entries in the path sequence (>=2).
- SEQ, figure-8 constant from package, STEP_COUNT*SEG_IDX_W bits; entry k sits at bits [k*SEG_IDX_W +: SEG_IDX_W]. SEG_IDX_W = $clog2(NUM_SEG).
- FADE_WIDTH, 4, brightness bits per segment; also the PWM counter width.
- PRESCALE_WIDTH, 23, width of the step prescaler (>=4).
- FADE_DIV_WIDTH, 22, width of the free-running fade-tick divider.

Ports:
- clk  in  1  sole clock.
- reset  in  1  synchronous, active-high.
- speed  in  3  step rate select; 0 is fastest.
- direction  in  1  1 = forward through SEQ, 0 = reverse.
- bounce  in  1  1 = ping-pong at the sequence ends instead of wrapping.
- tail_en  in  1  enables the fading tail.
- fade_linear  in  1  1 = decrement by 1 per fade tick, 0 = shift right by 1.
- pause  in  1  freezes the prescaler and position; fading continues.
- invert  in  1  inverts all led_out bits (common-anode displays).
- led_out  out  NUM_SEG  segment drive.
- pos  out  $clog2(STEP_COUNT)  current sequence index.
- step_pulse  out  1  high for one cycle when pos changes.

Behaviour:
- Every control input is registered once on clk; it takes effect from the following cycle.
- Reset: every register clears.
  - prescaler=0, fade divider=0, pwm_cnt=0.
  - pos=0, bounce_dir=up, all brightness=0.
  - led register=0, invert register=0, so led_out=0 and step_pulse=0.
- Reset asserted mid-run takes priority over every other update in that cycle.
- Prescaler limit L = {speed_r, (PRESCALE_WIDTH-3) ones}.
  - When not paused: if prescaler>=L, it loads 0 and raises step tick; otherwise it increments.
  - The >= compare makes a mid-count speed decrease wrap immediately.
  - When paused: the prescaler holds and no tick is raised.
- Step tick, bounce=0:
  - direction_r=1: pos+1, wrapping STEP_COUNT-1 to 0.
  - direction_r=0: pos-1, wrapping 0 to STEP_COUNT-1.
- Step tick, bounce=1:
  - Direction comes from the internal bounce_dir; direction_r is ignored.
  - Going up at STEP_COUNT-1: flip bounce_dir, move to STEP_COUNT-2.
  - Going down at 0: flip bounce_dir, move to 1.
  - When bounce changes 0 to 1, bounce_dir loads direction_r.
- step_pulse: registered; high in the cycle pos shows its new value.
- Fade tick: fires when the fade divider wraps from all-ones to 0, i.e. every 2^FADE_DIV_WIDTH cycles.
- Brightness update per segment, every cycle, highest priority first:
  1. Segment is SEQ[pos] (current registered pos): load all-ones.
  2. tail_en_r=0: load 0.
  3. Fade tick with fade_linear_r=1: saturating decrement (0 stays 0).
  4. Fade tick with fade_linear_r=0: logical shift right by 1.
  5. Otherwise: hold.
- SEQ may repeat an index (the default visits segment 6 twice); the rules above apply per segment, not per step.
- pwm_cnt: FADE_WIDTH-bit free-running up counter, wraps naturally.
- led register bit i = (brightness[i] > pwm_cnt).
  - Full brightness is therefore on for 2^FADE_WIDTH-1 of every 2^FADE_WIDTH cycles.
  - Brightness 0 is never on.
- led_out = led register XOR {NUM_SEG{invert_r}}.
- Latency: pos change, +1 cycle brightness=max, +1 cycle led register valid.
- SEQ entries >= NUM_SEG are illegal; the simulation assertion fires at elaboration.

Decomposition:
- Package segment_chaser_pkg holds:
  - SEG_FIG8_SEQ default constant (0,1,6,4,3,2,6,5; step 0 in the LSBs).
  - SEG_IDX_W helper function.
  - Fade-mode localparams.
- Sub-module seg_pwm_channel holds one brightness register, its decay/priority logic and the PWM compare; generated NUM_SEG times.
- Prescaler, position logic and the invert stage stay in the top module.

Test Plan (bench parameters: PRESCALE_WIDTH=6, FADE_DIV_WIDTH=5, FADE_WIDTH=4; speed=0 gives L=7):
- Reset held 3 cycles with invert=1 applied -> led_out=0, pos=0, step_pulse=0 during reset; after release, led_out reaches 7'h7F XOR register two cycles after invert_r=1.
- direction=1, bounce=0, speed=0 -> step_pulse every 8 cycles; pos 0..7 then 0; led bit SEQ[pos] duty 15/16; others 0 with tail_en=0.
- direction=0 from pos=0 -> next pos=7; speed=3 -> L=31, steps every 32 cycles.
- bounce=1, direction=1 -> pos 0..7, 6, 5, …, 0, 1; no repeated endpoint values.
- tail_en=1, fade_linear=0 -> on each fade tick a segment vacated by the head goes 15, 7, 3, 1, 0; with fade_linear=1 it goes 15, 14, 13, …, 0.
- pause=1 for 100 cycles mid-count -> pos and prescaler frozen, tails keep decaying; on release, stepping resumes from the held count.
